// File: rtl/axis_user_demux_n_if.sv
// rtl/axis_user_demux_n_if.sv - AXI4-Stream bundle, LANES parallel streams packed slice-per-lane
interface axis_user_demux_n_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128,
  parameter int LANES       = 1
);
  logic [LANES*DATA_WIDTH-1:0]   tdata;
  logic [LANES*DATA_WIDTH/8-1:0] tkeep;
  logic [LANES*TUSER_WIDTH-1:0]  tuser;
  logic [LANES-1:0]              tvalid;
  logic [LANES-1:0]              tlast;
  logic [LANES-1:0]              tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_user_demux_n.sv
// rtl/axis_user_demux_n.sv - 1-to-NUM_PORTS AXIS packet demux steered by tuser user_id
// Optional drop counter port enabled by defining AXIS_USER_DEMUX_DROP_CNT_EN.
module axis_user_demux_n #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 4,
  parameter int USER_ID_LSB        = 32,
  parameter int USER_ID_WIDTH      = 8
) (
  input  logic                  axis_aclk,
  input  logic                  axis_reset,
  axis_user_demux_n_if.slave    s_axis,
  axis_user_demux_n_if.master   m_axis
`ifdef AXIS_USER_DEMUX_DROP_CNT_EN
  ,
  output logic [31:0]           drop_count
`endif
);
  localparam int KEEP_WIDTH = C_AXIS_DATA_WIDTH / 8;
  localparam int DEST_W     = $clog2(NUM_PORTS);
  localparam int UID_CMP_W  = USER_ID_WIDTH + 5;

  typedef enum logic {IDLE, IN_PKT} state_t;
  state_t state, state_next;

  logic                          out_valid;
  logic [DEST_W-1:0]             dest_r;
  logic                          drop_r;
  logic [C_AXIS_DATA_WIDTH-1:0]  data_r;
  logic [KEEP_WIDTH-1:0]         keep_r;
  logic [C_AXIS_TUSER_WIDTH-1:0] user_r;
  logic                          last_r;

  logic [USER_ID_WIDTH-1:0]      user_id;
  logic                          id_drop;
  logic [DEST_W-1:0]             beat_dest;
  logic                          beat_drop;
  logic [2**DEST_W-1:0]          ready_pad;
  logic                          held_ready;
  logic                          s_ready;
  logic                          s_fire;

  assign user_id = s_axis.tuser[USER_ID_LSB +: USER_ID_WIDTH];
  assign id_drop = {5'd0, user_id} >= UID_CMP_W'(NUM_PORTS);

  // Pad tready to a power of two so dest_r can index it without a range hazard.
  always_comb begin
    ready_pad = '0;
    ready_pad[NUM_PORTS-1:0] = m_axis.tready;
  end

  // A held dropped beat is consumed unconditionally, so it never blocks the input.
  assign held_ready = drop_r || ready_pad[dest_r];
  assign s_ready    = !axis_reset && (!out_valid || held_ready);
  assign s_fire     = s_axis.tvalid[0] && s_ready;
  assign s_axis.tready = s_ready;

  always_comb begin
    state_next = state;
    beat_dest  = dest_r;
    beat_drop  = drop_r;
    case (state)
      IDLE: begin
        beat_dest = user_id[DEST_W-1:0];
        beat_drop = id_drop;
        if (s_fire && !s_axis.tlast[0]) state_next = IN_PKT;
      end
      IN_PKT: begin
        if (s_fire && s_axis.tlast[0]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      dest_r    <= '0;
      drop_r    <= 1'b0;
      data_r    <= '0;
      keep_r    <= '0;
      user_r    <= '0;
      last_r    <= 1'b0;
    end else begin
      state <= state_next;
      if (s_fire) begin
        out_valid <= 1'b1;
        dest_r    <= beat_dest;
        drop_r    <= beat_drop;
        data_r    <= s_axis.tdata;
        keep_r    <= s_axis.tkeep;
        user_r    <= s_axis.tuser;
        last_r    <= s_axis.tlast[0];
      end else if (out_valid && held_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef AXIS_USER_DEMUX_DROP_CNT_EN
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      drop_count <= '0;
    end else if (s_fire && (state == IDLE) && id_drop && (drop_count != 32'hFFFF_FFFF)) begin
      drop_count <= drop_count + 32'd1;
    end
  end
`endif

  assign m_axis.tdata = {NUM_PORTS{data_r}};
  assign m_axis.tkeep = {NUM_PORTS{keep_r}};
  assign m_axis.tuser = {NUM_PORTS{user_r}};
  assign m_axis.tlast = {NUM_PORTS{last_r}};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_valid
    assign m_axis.tvalid[i] = out_valid && !drop_r && (dest_r == DEST_W'(i));
  end
endmodule
